// File: rtl/seg7_scan.sv
// seg7_scan: converts an unsigned binary value to BCD with a sequential
// shift-add-3 FSM and drives a multiplexed, active-low 7-segment display.
// The display shows only the last committed conversion, while digit scanning
// runs continuously and independently of any conversion.
module seg7_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_W-1:0]     value_i,
  input  logic                  load_i,
  input  logic                  blank_zero_i,
  input  logic [NUM_DIGITS-1:0] dp_i,
  output logic                  busy_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHIFT_LAST = CW'(DATA_W - 1);
  localparam logic [PW-1:0] PRE_MAX    = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(NUM_DIGITS - 1);

  // Largest value the display can show: 10^NUM_DIGITS - 1.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] MAX_SHOW = pow10(NUM_DIGITS) - 64'd1;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h18;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DATA_W-1:0]       shreg;
  logic [BW-1:0]           bcd;
  logic [BW-1:0]           bcd_adj;
  logic                    ovf_pend;
  logic [BW-1:0]           digits;
  logic                    ovf;
  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_above;
  logic [3:0]              cur_nib;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture, shift one bit per cycle MSB first, then commit
  // digits and overflow together so a partial result is never displayed.
  // Carries out of the top digit are dropped; that case is already flagged
  // as overflow at capture time and shows dashes instead of digits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      cnt      <= '0;
      shreg    <= '0;
      bcd      <= '0;
      ovf_pend <= 1'b0;
      digits   <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            shreg    <= value_i;
            bcd      <= '0;
            cnt      <= SHIFT_LAST;
            ovf_pend <= ({{(64-DATA_W){1'b0}}, value_i} > MAX_SHOW);
            busy_o   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd   <= BW'({bcd_adj, shreg[DATA_W-1]});
          shreg <= {shreg[DATA_W-2:0], 1'b0};
          if (cnt == '0) begin
            busy_o <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          digits <= bcd;
          ovf    <= ovf_pend;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Scan prescaler and digit index; free-running, never touched by a commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Mark digits that sit above the most significant nonzero digit.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above && (digits[4*k +: 4] == 4'd0);
      blank_mask[k] = zero_above;
    end
  end

  // Drive the active digit: anode, segments and decimal point together.
  always_comb begin
    cur_nib = digits[4*int'(idx) +: 4];
    an_o    = ~(NUM_DIGITS'(1) << idx);
    dp_o    = ~dp_i[idx];
    if (ovf) begin
      seg_o = 7'h3F;
    end else if (blank_zero_i && blank_mask[idx]) begin
      seg_o = 7'h7F;
    end else begin
      seg_o = seg_decode(cur_nib);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized bench for seg7_scan (4 digits, 14-bit input,
// 4-cycle scan slots) checked every cycle against a decimal-arithmetic model.
module tb_seg7_scan;

  logic        clk_i;
  logic        rst_ni;
  logic [13:0] value_i;
  logic        load_i;
  logic        blank_zero_i;
  logic [3:0]  dp_i;
  logic        busy_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;

  int checks;
  int failures;
  logic mon_en;

  // Model state: posedges since reset release, accepted load cycle, shown value.
  int m_n;
  int m_acc;
  int m_cap;
  int m_shown;

  int pw10 [0:3];
  logic [6:0] codes [0:9];

  int k;
  int d;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic exp_dp;
  logic exp_busy;

  seg7_scan #(
    .NUM_DIGITS(4),
    .DATA_W(14),
    .REFRESH_DIV(4)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .value_i(value_i),
    .load_i(load_i),
    .blank_zero_i(blank_zero_i),
    .dp_i(dp_i),
    .busy_o(busy_o),
    .seg_o(seg_o),
    .dp_o(dp_o),
    .an_o(an_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: a load is accepted when no conversion is running
  // (the previous one ended its 16-cycle capture/shift/done window), busy
  // covers 14 cycles, and the value appears one cycle after busy drops.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_n     <= 0;
      m_acc   <= -1;
      m_cap   <= 0;
      m_shown <= 0;
    end else begin
      if (m_acc >= 0 && m_n + 1 == m_acc + 15) m_shown <= m_cap;
      if (load_i && (m_acc < 0 || m_n + 1 >= m_acc + 16)) begin
        m_acc <= m_n + 1;
        m_cap <= int'(value_i);
      end
      m_n <= m_n + 1;
    end
  end

  // Compare every display output and busy against the model each cycle.
  always @(negedge clk_i) begin
    if (mon_en) begin
      k = (m_n / 4) % 4;
      d = (m_shown / pw10[k]) % 10;
      exp_an = ~(4'b0001 << k);
      exp_dp = ~dp_i[k];
      if (m_shown > 9999) exp_seg = 7'h3F;
      else if (blank_zero_i && k > 0 && m_shown < pw10[k]) exp_seg = 7'h7F;
      else exp_seg = codes[d];
      exp_busy = (m_acc >= 0 && m_n >= m_acc && m_n <= m_acc + 13);
      checkOutput("an", 32'(an_o), 32'(exp_an));
      checkOutput("seg", 32'(seg_o), 32'(exp_seg));
      checkOutput("dp", 32'(dp_o), 32'(exp_dp));
      checkOutput("busy", 32'(busy_o), 32'(exp_busy));
    end
  end

  task automatic applyStimulus(input logic [13:0] val, input int wait_cycles);
    @(posedge clk_i); #1;
    value_i = val;
    load_i  = 1'b1;
    @(posedge clk_i); #1;
    load_i  = 1'b0;
    repeat (wait_cycles) @(posedge clk_i);
  endtask

  task automatic setInputs(input logic bz, input logic [3:0] dp);
    @(posedge clk_i); #1;
    blank_zero_i = bz;
    dp_i         = dp;
  endtask

  task automatic resetMidShift(input logic [13:0] val);
    applyStimulus(val, 5);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_seg", 32'(seg_o), 32'h40);
    checkOutput("rst_an", 32'(an_o), 32'hE);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (30) @(posedge clk_i);
  endtask

  initial begin
    pw10  = '{1, 10, 100, 1000};
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
    checks = 0;
    failures = 0;
    mon_en = 1'b0;
    clk_i = 1'b0;
    rst_ni = 1'b0;
    value_i = '0;
    load_i = 1'b0;
    blank_zero_i = 1'b0;
    dp_i = 4'b0000;

    #2;
    checkOutput("reset_an", 32'(an_o), 32'hE);
    checkOutput("reset_seg", 32'(seg_o), 32'h40);
    checkOutput("reset_dp", 32'(dp_o), 32'd1);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    mon_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Directed cases: plain value, blanking, overflow, dp, ignored reload.
    applyStimulus(14'd1234, 24);
    setInputs(1'b0, 4'b0100);
    applyStimulus(14'd7, 20);
    setInputs(1'b1, 4'b0100);
    repeat (20) @(posedge clk_i);
    applyStimulus(14'd10000, 20);
    setInputs(1'b0, 4'b0000);
    repeat (20) @(posedge clk_i);
    applyStimulus(14'd0, 20);
    applyStimulus(14'd9999, 3);
    applyStimulus(14'd42, 30);
    resetMidShift(14'd5678);

    // Randomized loads, input changes, overlapping loads and resets.
    for (int it = 0; it < 80; it++) begin
      logic [13:0] v;
      case ($urandom_range(0, 5))
        0: v = 14'($urandom_range(0, 99));
        1: v = 14'd9999;
        2: v = 14'($urandom_range(10000, 16383));
        3: v = 14'($urandom_range(0, 9));
        default: v = 14'($urandom_range(0, 16383));
      endcase
      setInputs(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) == 0) begin
        resetMidShift(v);
      end else if ($urandom_range(0, 3) == 0) begin
        applyStimulus(v, 3);
        applyStimulus(14'($urandom_range(0, 16383)), $urandom_range(12, 30));
      end else begin
        applyStimulus(v, $urandom_range(14, 40));
      end
    end

    repeat (20) @(posedge clk_i);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
